ring_arbiter: RTL and testbench
===============================

Name: ring_arbiter

Overview:
- Round-robin arbiter that shares one resource (bus, output register, ring datapath) among N requesters.
- Priority is a one-hot ring token that rotates one position past each released owner, wrapping from bit N-1 to bit 0.
- The arbiter limits each grant tenure to MAX_HOLD cycles, so no requester can starve the others.
- Sits between requester blocks and the shared resource; the one-hot grant drives the resource's select/enable lines directly.

Parameters:
- N, 4, number of requesters (>=2).
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (>=1).
- HW, $clog2(MAX_HOLD+1), hold counter width (derived; do not override).
- IW, $clog2(N), grant index width (derived).

Ports:
- c  in  1  clock, rising edge.
- r  in  1  reset, asynchronous, active-low; clears all state immediately.
- req  in  N  request per requester; level-held while the requester wants the resource.
- gnt  out  N  one-hot grant, or all zeros when idle; registered.
- gnt_id  out  IW  binary index of the current owner; 0 when idle.
- busy  out  1  high while any grant is active (equals |gnt).
- ptr  out  N  one-hot priority token; its set bit is the highest priority for the next arbitration.

Behaviour:
- Reset (r=0, async): ptr=0001 (bit 0), gnt=0, gnt_id=0, busy=0, hold_cnt=0, state=IDLE. Reset mid-grant drops gnt on the same instant; no pending grant survives reset.
- States: IDLE, GRANT.
- IDLE:
  - If |req at a rising edge, pick the first set req bit scanning from the ptr position upward with wrap.
  - Load gnt/gnt_id/busy with the winner; hold_cnt=1; go to GRANT.
  - Latency: req sampled at edge k -> gnt visible after edge k (one registered cycle). No req -> remain IDLE with outputs 0.
- GRANT, owner k, release condition = (req[k]==0) or (hold_cnt==MAX_HOLD):
  - No release: keep gnt; hold_cnt++.
  - Release: ptr <= one-hot bit (k+1) mod N.
    - Re-arbitrate in the same edge using the new ptr and the current req vector, including req[k] at the lowest priority.
    - Any winner: gnt switches owners with no idle bubble; hold_cnt=1; stay in GRANT.
    - No winner: gnt=0, busy=0, hold_cnt=0, go to IDLE.
- Expired owner still requesting: if no other req is set, the same owner is re-granted with hold_cnt=1 and ptr has still advanced.
- ptr changes only on release; it never changes in IDLE.
- MAX_HOLD=1 gives strict per-cycle round robin.
- Invariants (bench assertions):
  - gnt is one-hot or zero.
  - busy == |gnt.
  - gnt_id == index(gnt) when busy.
  - ptr is always exactly one-hot.
  - hold_cnt never exceeds MAX_HOLD.
- Unrequested grants are impossible except for the single cycle after an owner drops req.

Decomposition:
- Package ring_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - default N and MAX_HOLD constants;
  - function onehot2idx (one-hot to binary index);
  - function rotl1 (one-hot rotate left by one with wrap).
- Sub-module ring_pick: combinational rotating priority picker, inputs (req, ptr), output one-hot winner plus a valid flag. The top module holds the FSM, hold counter, ptr and output registers.

Test Plan:
- Reset then req=0000 for 5 cycles -> gnt=0000, busy=0, ptr=0001 throughout.
- N=4, MAX_HOLD=8, req=1111 held for 32 cycles -> owner sequence 0,1,2,3 with 8 cycles each, zero-bubble handoffs; ptr steps 0010, 0100, 1000, 0001.
- req=0100 for 3 cycles then 0 -> gnt=0100 for 3 cycles, then gnt=0000, IDLE, ptr=1000; next req=0101 -> gnt=0001 (wrap past bit 3).
- req=0001 held alone, MAX_HOLD=8 -> gnt=0001 continuous; hold_cnt wraps 8->1 and ptr advances on each expiry.
- Owner 2 drops req on the same edge req[0] and req[3] rise -> next gnt=1000 (ptr=1000 takes priority), no idle cycle.
- Assert r=0 mid-grant (gnt=0010, hold_cnt=5) between clock edges -> gnt=0000, ptr=0001 immediately; after release the first grant follows priority from bit 0.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// Shared types and one-hot helpers for the round-robin ring arbiter.
// Helpers work on 32-bit vectors; callers size-cast to their own width.
package ring_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;

  function automatic int onehot2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh == (32'd1 << i)) idx = i;
    end
    return idx;
  endfunction

  // Rotate within the low n bits, so bit n-1 wraps to bit 0.
  function automatic logic [31:0] rotl1(input logic [31:0] oh, input int n);
    logic [31:0] mask;
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    return ((oh << 1) | (oh >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/ring_pick.sv
// Rotating priority picker: first set req bit at or above the one-hot ptr,
// wrapping to the lowest set bit when nothing at or above ptr is requesting.
module ring_pick
  import ring_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] win,
  output logic         valid
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] req_hi;

  // ptr is one-hot, so ~(ptr-1) selects ptr and every bit above it.
  assign hi_mask = ~(ptr - N'(1));
  assign req_hi  = req & hi_mask;
  assign win     = (|req_hi) ? (req_hi & (~req_hi + N'(1)))
                             : (req & (~req + N'(1)));
  assign valid   = |req;

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin ring arbiter with a per-owner hold limit and registered one-hot grant.
// state | meaning: IDLE | no owner, outputs zero; GRANT | gnt holds current owner
module ring_arbiter
  import ring_arb_pkg::*;
#(
  parameter int  N        = N_DEF,
  parameter int  MAX_HOLD = MAX_HOLD_DEF,
  localparam int HW       = $clog2(MAX_HOLD + 1),
  localparam int IW       = $clog2(N)
) (
  input  logic          c,
  input  logic          r,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic [N-1:0]  ptr
);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          owner_req;
  logic          release_own;
  logic          win_valid;
  logic [N-1:0]  ptr_rot;
  logic [N-1:0]  ptr_arb;
  logic [N-1:0]  win;
  logic [IW-1:0] win_id;

  assign owner_req   = |(req & gnt);
  assign release_own = (state == GRANT) && (!owner_req || (hold_cnt == HW'(MAX_HOLD)));
  assign ptr_rot     = N'(rotl1(32'(gnt), N));
  // On release the re-arbitration already uses the advanced token.
  assign ptr_arb     = release_own ? ptr_rot : ptr;
  assign win_id      = IW'(onehot2idx(32'(win)));

  ring_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr_arb),
    .win  (win),
    .valid(win_valid)
  );

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      ptr      <= N'(1);
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            gnt      <= win;
            gnt_id   <= win_id;
            busy     <= 1'b1;
            hold_cnt <= HW'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!release_own) begin
            hold_cnt <= hold_cnt + HW'(1);
          end else begin
            ptr <= ptr_rot;
            if (win_valid) begin
              gnt      <= win;
              gnt_id   <= win_id;
              hold_cnt <= HW'(1);
            end else begin
              gnt      <= '0;
              gnt_id   <= '0;
              busy     <= 1'b0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed and random stimulus for ring_arbiter, checked against an
// owner/ptr-index reference model of the round-robin rules.
module tb_ring_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IW       = 2;

  logic          c = 1'b0;
  logic          r = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic [N-1:0]  ptr;

  int vectors     = 0;
  int miscompares = 0;

  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;

  always #5 c = ~c;

  ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .c     (c),
    .r     (r),
    .req   (req),
    .gnt   (gnt),
    .gnt_id(gnt_id),
    .busy  (busy),
    .ptr   (ptr)
  );

  function automatic int scan(input logic [N-1:0] rq, input int from);
    logic [N-1:0] t;
    int k;
    for (int i = 0; i < N; i++) begin
      k = (from + i) % N;
      t = rq >> k;
      if (t[0]) return k;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic [N-1:0] rq);
    logic [N-1:0] t;
    if (m_owner < 0) begin
      m_owner = scan(rq, m_ptr);
      m_hold  = (m_owner < 0) ? 0 : 1;
    end else begin
      t = rq >> m_owner;
      if (!t[0] || m_hold == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = scan(rq, m_ptr);
        m_hold  = (m_owner < 0) ? 0 : 1;
      end else begin
        m_hold++;
      end
    end
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
  endfunction

  task automatic check(input string tag);
    logic [N-1:0]  eg;
    logic [IW-1:0] ei;
    logic          eb;
    logic [N-1:0]  ep;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    ei = (m_owner < 0) ? '0 : IW'(m_owner);
    eb = (m_owner >= 0);
    ep = N'(1) << m_ptr;
    vectors++;
    assert (gnt === eg) else begin
      miscompares++;
      $error("FAIL %s gnt: observed %b expected %b", tag, gnt, eg);
    end
    vectors++;
    assert (gnt_id === ei) else begin
      miscompares++;
      $error("FAIL %s gnt_id: observed %0d expected %0d", tag, gnt_id, ei);
    end
    vectors++;
    assert (busy === eb) else begin
      miscompares++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, eb);
    end
    vectors++;
    assert (ptr === ep) else begin
      miscompares++;
      $error("FAIL %s ptr: observed %b expected %b", tag, ptr, ep);
    end
    vectors++;
    assert ($onehot0(gnt) && $onehot(ptr) && (busy === |gnt)) else begin
      miscompares++;
      $error("FAIL %s invariant: observed gnt=%b ptr=%b busy=%b expected onehot0/onehot/busy=|gnt",
             tag, gnt, ptr, busy);
    end
  endtask

  task automatic step(input logic [N-1:0] rq, input string tag);
    req = rq;
    @(posedge c);
    if (r) model_edge(rq);
    @(negedge c);
    check(tag);
  endtask

  // Reset lands between edges so the asynchronous clear is observed immediately.
  task automatic async_reset(input string tag);
    #2;
    r = 1'b0;
    #1;
    model_reset();
    check(tag);
    @(negedge c);
    r = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rq;

    @(negedge c);
    @(negedge c);
    model_reset();
    check("reset");
    r = 1'b1;

    for (int i = 0; i < 5; i++) step(4'b0000, "idle");

    for (int i = 0; i < 32; i++) step(4'b1111, "all_req");

    async_reset("rst_a");
    for (int i = 0; i < 3; i++) step(4'b0100, "single2");
    step(4'b0000, "drop2");
    step(4'b0000, "idle2");
    step(4'b0101, "wrap");
    step(4'b0101, "wrap_hold");

    async_reset("rst_b");
    for (int i = 0; i < 20; i++) step(4'b0001, "solo0");

    async_reset("rst_c");
    step(4'b0100, "own2");
    step(4'b0100, "own2b");
    step(4'b1001, "handoff");
    step(4'b1001, "handoff2");

    async_reset("rst_d");
    for (int i = 0; i < 5; i++) step(4'b0010, "own1");
    async_reset("mid_grant_rst");
    step(4'b1111, "after_rst");
    step(4'b1111, "after_rst2");

    rq = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      step(rq, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
